// File: rtl/tx_interp_chain.sv
// tx_interp_chain: transmit interpolation chain.
// 2-bit Gray symbols are mapped to 4-ASK levels and zero-stuffed 4x at sam_clk
// (stage0). Two identical 7-tap half-band filters then interpolate 2x at
// clk_int (stage1) and 2x at clk (stage2). Each half-band has a DC gain of 2.
//
// Timing:
//   - A symbol is loaded into s0 at clk edge t (sym_clk & sam_clk).
//   - It enters stage1 x0 at t+4, the next clk_int edge that also carries
//     sam_clk. The clk_int edge at t+2 shifts in a stuffed zero.
//   - An impulse (test_mode) reaches its centre peak on data_out right after
//     the clk edge at t+18. This offset is fixed.
//
// Filter arithmetic:
//   - stage0 carries up to +/-3*LEVEL, which needs 20 bits.
//   - The half-band accumulator is therefore 26 bits wide and cannot overflow.
//   - Results are the floor of sum/16, then clamped (SAT_EN=1) or wrapped
//     (SAT_EN=0) to 18 bits.
//
// Impulse mode: the impulse-done flag is set only when an impulse is actually
// injected, so enabling test_mode later in a run injects one impulse at the
// next symbol instant.
module tx_interp_chain #(
  parameter logic signed [17:0] LEVEL  = 18'sd8192,
  parameter bit                 SAT_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sym_clk,
  input  logic               sam_clk,
  input  logic               clk_int,
  input  logic [1:0]         sym_in,
  input  logic               test_mode,
  output logic signed [17:0] data_out,
  output logic signed [17:0] stage1_out,
  output logic               align_err
);

  localparam int TW = 20;
  localparam int SW = 26;
  localparam logic signed [TW-1:0] LVL_A  = {{2{LEVEL[17]}}, LEVEL};
  localparam logic signed [TW-1:0] LVL_3A = LVL_A + LVL_A + LVL_A;
  localparam logic signed [SW-1:0] SAT_HI = 26'sd131071;
  localparam logic signed [SW-1:0] SAT_LO = -26'sd131072;

  // Sign-extend an 18-bit sample to the filter tap width.
  function automatic logic signed [TW-1:0] widen(input logic signed [17:0] v);
    widen = {{2{v[17]}}, v};
  endfunction

  // Half-band kernel -1,0,9,16,9,0,-1, scaled by 1/16 with floor rounding.
  function automatic logic signed [17:0] hb_filter(
    input logic signed [TW-1:0] x0,
    input logic signed [TW-1:0] x2,
    input logic signed [TW-1:0] x3,
    input logic signed [TW-1:0] x4,
    input logic signed [TW-1:0] x6
  );
    logic signed [SW-1:0] e0, e2, e3, e4, e6, sum, res;
    e0  = {{(SW-TW){x0[TW-1]}}, x0};
    e2  = {{(SW-TW){x2[TW-1]}}, x2};
    e3  = {{(SW-TW){x3[TW-1]}}, x3};
    e4  = {{(SW-TW){x4[TW-1]}}, x4};
    e6  = {{(SW-TW){x6[TW-1]}}, x6};
    sum = (e2 <<< 3) + e2 + (e3 <<< 4) + (e4 <<< 3) + e4 - e0 - e6;
    res = sum >>> 4;
    if (SAT_EN) begin
      if (res > SAT_HI) begin
        hb_filter = 18'sd131071;
      end else if (res < SAT_LO) begin
        hb_filter = 18'sh20000;
      end else begin
        hb_filter = res[17:0];
      end
    end else begin
      hb_filter = res[17:0];
    end
  endfunction

  logic                    sym_ok_s;
  logic signed [TW-1:0]    mapped_s;
  logic signed [TW-1:0]    load_val_s;
  logic signed [17:0]      hb1_s;
  logic signed [17:0]      hb2_s;
  logic signed [TW-1:0]    s0_r;
  logic                    imp_done_r;
  logic signed [TW-1:0]    taps1_r [7];
  logic signed [17:0]      taps2_r [7];

  // Symbol mapping, impulse selection and both half-band results.
  always_comb begin
    sym_ok_s = sym_clk & sam_clk;
    case (sym_in)
      2'b00:   mapped_s = -LVL_3A;
      2'b01:   mapped_s = -LVL_A;
      2'b11:   mapped_s = LVL_A;
      2'b10:   mapped_s = LVL_3A;
      default: mapped_s = {TW{1'b0}};
    endcase
    if (test_mode) begin
      if (imp_done_r) begin
        load_val_s = {TW{1'b0}};
      end else begin
        load_val_s = LVL_A;
      end
    end else begin
      load_val_s = mapped_s;
    end
    hb1_s = hb_filter(taps1_r[0], taps1_r[2], taps1_r[3], taps1_r[4], taps1_r[6]);
    hb2_s = hb_filter(widen(taps2_r[0]), widen(taps2_r[2]), widen(taps2_r[3]),
                      widen(taps2_r[4]), widen(taps2_r[6]));
  end

  // Stage0: 4x zero-stuff at sam_clk and the one-shot impulse flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0_r       <= {TW{1'b0}};
      imp_done_r <= 1'b0;
    end else begin
      if (sam_clk) begin
        if (sym_ok_s) begin
          s0_r <= load_val_s;
        end else begin
          s0_r <= {TW{1'b0}};
        end
      end
      if (sym_ok_s && test_mode) begin
        imp_done_r <= 1'b1;
      end
    end
  end

  // Stage1: filter the current taps, then shift in the 2x-stuffed stage0 sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage1_out <= 18'sd0;
      for (int k = 0; k < 7; k++) taps1_r[k] <= {TW{1'b0}};
    end else if (clk_int) begin
      stage1_out <= hb1_s;
      taps1_r[0] <= sam_clk ? s0_r : {TW{1'b0}};
      for (int k = 1; k < 7; k++) taps1_r[k] <= taps1_r[k-1];
    end
  end

  // Stage2: filter every clk, then shift in the 2x-stuffed stage1 sample.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= 18'sd0;
      for (int k = 0; k < 7; k++) taps2_r[k] <= 18'sd0;
    end else begin
      data_out   <= hb2_s;
      taps2_r[0] <= clk_int ? stage1_out : 18'sd0;
      for (int k = 1; k < 7; k++) taps2_r[k] <= taps2_r[k-1];
    end
  end

  // Sticky flag for enables that do not nest sym_clk within sam_clk within clk_int.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      align_err <= 1'b0;
    end else if ((sym_clk & ~sam_clk) | (sam_clk & ~clk_int)) begin
      align_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tx_interp_chain.sv
// Testbench for tx_interp_chain: four instances (impulse LEVEL=16, default
// LEVEL, saturating LEVEL=60000, wrapping LEVEL=60000) share one stimulus and
// are compared every clk against a history-array convolution model.
module tb_tx_interp_chain;

  localparam int HMAX = 4096;

  logic               clk = 1'b0;
  logic               reset;
  logic               sym_clk;
  logic               sam_clk;
  logic               clk_int;
  logic [1:0]         sym_in;
  logic               test_mode;
  logic signed [17:0] dout_w [4];
  logic signed [17:0] s1_w   [4];
  logic               aerr_w [4];

  always #5 clk = ~clk;

  tx_interp_chain #(.LEVEL(18'sd16), .SAT_EN(1'b1)) u_imp (
    .clk(clk), .reset(reset), .sym_clk(sym_clk), .sam_clk(sam_clk), .clk_int(clk_int),
    .sym_in(sym_in), .test_mode(test_mode), .data_out(dout_w[0]), .stage1_out(s1_w[0]),
    .align_err(aerr_w[0]));
  tx_interp_chain #(.LEVEL(18'sd8192), .SAT_EN(1'b1)) u_dc (
    .clk(clk), .reset(reset), .sym_clk(sym_clk), .sam_clk(sam_clk), .clk_int(clk_int),
    .sym_in(sym_in), .test_mode(test_mode), .data_out(dout_w[1]), .stage1_out(s1_w[1]),
    .align_err(aerr_w[1]));
  tx_interp_chain #(.LEVEL(18'sd60000), .SAT_EN(1'b1)) u_sat (
    .clk(clk), .reset(reset), .sym_clk(sym_clk), .sam_clk(sam_clk), .clk_int(clk_int),
    .sym_in(sym_in), .test_mode(test_mode), .data_out(dout_w[2]), .stage1_out(s1_w[2]),
    .align_err(aerr_w[2]));
  tx_interp_chain #(.LEVEL(18'sd60000), .SAT_EN(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .sym_clk(sym_clk), .sam_clk(sam_clk), .clk_int(clk_int),
    .sym_in(sym_in), .test_mode(test_mode), .data_out(dout_w[3]), .stage1_out(s1_w[3]),
    .align_err(aerr_w[3]));

  longint levs [4] = '{16, 8192, 60000, 60000};
  bit     sats [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  int     coef [7] = '{-1, 0, 9, 16, 9, 0, -1};

  longint m_s0 [4];
  longint m_s1 [4];
  longint m_do [4];
  bit     m_al [4];
  bit     m_done [4];
  int     n1 [4];
  int     n2 [4];
  longint h1 [4][HMAX];
  longint h2 [4][HMAX];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_s0[i] = 0; m_s1[i] = 0; m_do[i] = 0; m_al[i] = 1'b0; m_done[i] = 1'b0;
      n1[i] = 0; n2[i] = 0;
    end
  endtask

  // Convolve the last seven inputs of a stage with the kernel, floor /16, then clamp or wrap.
  function automatic longint conv(input int i, input bit stg);
    longint acc = 0;
    longint r;
    int n = stg ? n2[i] : n1[i];
    for (int j = 0; j < 7; j++) begin
      if (n - 1 - j >= 0) acc += coef[j] * (stg ? h2[i][n-1-j] : h1[i][n-1-j]);
    end
    r = acc >>> 4;
    if (sats[i]) begin
      if (r > 131071) r = 131071;
      if (r < -131072) r = -131072;
    end else begin
      r = r & 262143;
      if (r >= 131072) r = r - 262144;
    end
    return r;
  endfunction

  task automatic model_step();
    longint old_s0, old_s1;
    int b;
    for (int i = 0; i < 4; i++) begin
      if (!reset) begin
        m_s0[i] = 0; m_s1[i] = 0; m_do[i] = 0; m_al[i] = 1'b0; m_done[i] = 1'b0;
        n1[i] = 0; n2[i] = 0;
      end else begin
        old_s0 = m_s0[i];
        old_s1 = m_s1[i];
        if (sam_clk) begin
          if (sym_clk) begin
            if (test_mode) begin
              m_s0[i] = m_done[i] ? 0 : levs[i];
              m_done[i] = 1'b1;
            end else begin
              b = 2 * int'(sym_in[1]) + int'(sym_in[1] ^ sym_in[0]);
              m_s0[i] = (2 * b - 3) * levs[i];
            end
          end else begin
            m_s0[i] = 0;
          end
        end
        if (clk_int) begin
          m_s1[i] = conv(i, 1'b0);
          if (n1[i] < HMAX) begin h1[i][n1[i]] = sam_clk ? old_s0 : 0; n1[i]++; end
        end
        m_do[i] = conv(i, 1'b1);
        if (n2[i] < HMAX) begin h2[i][n2[i]] = clk_int ? old_s1 : 0; n2[i]++; end
        if ((sym_clk && !sam_clk) || (sam_clk && !clk_int)) m_al[i] = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("data_out[%0d]", i), dout_w[i], m_do[i]);
      check_val($sformatf("stage1_out[%0d]", i), s1_w[i], m_s1[i]);
      check_val($sformatf("align_err[%0d]", i), aerr_w[i], m_al[i]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic std_en(input int c);
    sym_clk = (c % 16 == 0);
    sam_clk = (c % 4 == 0);
    clk_int = (c % 2 == 0);
  endtask

  task automatic hard_reset();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    compare_all();
    sym_clk = 1'b0; sam_clk = 1'b0; clk_int = 1'b0; test_mode = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic impulse_run(output int off);
    longint s1seq [$];
    longint dseq [$];
    longint exp1 [7] = '{-1, 0, 9, 16, 9, 0, -1};
    longint shape [17] = '{0, -1, -1, -2, 0, 4, 9, 13, 16, 13, 9, 4, 0, -2, -1, -1, 0};
    int load_cyc = -1;
    int f = -1;
    int pk = 0;
    test_mode = 1'b1;
    for (int c = 0; c < 80; c++) begin
      std_en(c);
      sym_in = 2'($urandom_range(0, 3));
      tick();
      if (sym_clk && sam_clk && load_cyc < 0) load_cyc = c;
      if (clk_int) s1seq.push_back(s1_w[0]);
      dseq.push_back(dout_w[0]);
    end
    for (int k = 0; k < s1seq.size(); k++) if (f < 0 && s1seq[k] != 0) f = k;
    check_val("imp_s1_found", (f >= 0 && f + 6 < s1seq.size()) ? 1 : 0, 1);
    if (f >= 0 && f + 6 < s1seq.size()) begin
      for (int k = 0; k < 7; k++) check_val("imp_s1_seq", s1seq[f+k], exp1[k]);
    end
    for (int k = 0; k < dseq.size(); k++) if (dseq[k] > dseq[pk]) pk = k;
    check_val("imp_peak", dseq[pk], 16);
    off = pk - load_cyc;
    check_val("imp_offset", off, 18);
    for (int d = -8; d <= 8; d++) begin
      if (pk + d >= 0 && pk + d < dseq.size()) check_val("imp_shape", dseq[pk+d], shape[d+8]);
      else check_val("imp_shape_range", pk + d, 18 + d);
    end
    for (int k = pk + 9; k < dseq.size(); k++) check_val("imp_tail_zero", dseq[k], 0);
  endtask

  task automatic dc_run();
    longint sum1 = 0;
    longint max2 = -1000000;
    longint min2 = 1000000;
    longint min3 = 1000000;
    test_mode = 1'b0;
    sym_in = 2'b10;
    for (int c = 0; c < 160; c++) begin
      std_en(c);
      tick();
      if (c >= 96) sum1 += dout_w[1];
      if (dout_w[2] > max2) max2 = dout_w[2];
      if (dout_w[2] < min2) min2 = dout_w[2];
      if (dout_w[3] < min3) min3 = dout_w[3];
    end
    // 3A per 16 clk, total filter gain 4: mean = 3A*4/16 per clk, summed over 64 clk.
    check_val("dc_mean_x64", sum1, 64 * (3 * levs[1] * 4 / 16));
    check_val("sat_peak", max2, 131071);
    check_val("sat_no_wrap", (min2 > -65536) ? 1 : 0, 1);
    check_val("wrap_seen", (min3 < -65536) ? 1 : 0, 1);
  endtask

  task automatic random_run();
    for (int c = 0; c < 480; c++) begin
      std_en(c);
      if (c % 16 == 8) test_mode = ($urandom_range(0, 7) == 0);
      sym_in = 2'($urandom_range(0, 3));
      tick();
    end
  endtask

  initial begin
    int off1, off2;
    reset = 1'b0; sym_clk = 1'b0; sam_clk = 1'b0; clk_int = 1'b0;
    sym_in = 2'b00; test_mode = 1'b0;
    model_reset();
    for (int c = 0; c < 20; c++) begin
      sym_clk = 1'($urandom_range(0, 1));
      sam_clk = 1'($urandom_range(0, 1));
      clk_int = 1'($urandom_range(0, 1));
      sym_in = 2'($urandom_range(0, 3));
      test_mode = 1'($urandom_range(0, 1));
      tick();
      check_val("rst_hold_dout", dout_w[1], 0);
      check_val("rst_hold_align", aerr_w[1], 0);
    end
    sym_clk = 1'b0; sam_clk = 1'b0; clk_int = 1'b0; test_mode = 1'b0;
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      check_val("idle_dout", dout_w[1], 0);
    end
    impulse_run(off1);
    hard_reset();
    impulse_run(off2);
    check_val("imp_offset_stable", off2, off1);
    hard_reset();
    dc_run();
    hard_reset();
    random_run();
    check_val("align_clear", aerr_w[0], 0);
    sym_clk = 1'b1; sam_clk = 1'b0; clk_int = 1'b1; test_mode = 1'b0;
    tick();
    check_val("align_set", aerr_w[0], 1);
    for (int c = 0; c < 20; c++) begin
      std_en(c + 1);
      sym_in = 2'($urandom_range(0, 3));
      tick();
      check_val("align_sticky", aerr_w[1], 1);
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 4; i++) begin
      check_val("midrst_dout", dout_w[i], 0);
      check_val("midrst_s1", s1_w[i], 0);
      check_val("midrst_align", aerr_w[i], 0);
    end
    sym_clk = 1'b0; sam_clk = 1'b0; clk_int = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      for (int i = 0; i < 4; i++) check_val("post_rst_zero", dout_w[i], 0);
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
